theta_stream: RTL

Parametrised Keccak theta-step engine for the hashing datapath. It accepts one complete state as DEPTH 25-bit pages (one slice z per page) over a valid/ready stream and buffers it. It then emits the theta-transformed pages in order, including the cyclic z-wrap between the last and first pages. A bypass mode passes pages through unchanged. The block sits between the state memory and the rho/pi stage.

---
 rtl/keccak_pkg.sv | 32 +++
 rtl/theta_slice.sv | 32 +++
 rtl/theta_stream.sv | 134 +++++++++++++
 3 files changed

// File: rtl/keccak_pkg.sv
// Shared Keccak datapath definitions.
//   page_t     : one 25-bit slice A[x][y] of a state, bit 5*y+x
//   col_par_t  : the five column parities C[x] of one slice
//   state_e    : sequencing states of the theta stream engine
//   col_parity : XOR of the five rows of a slice, per column
package keccak_pkg;

   localparam int PAGE_W = 25;
   localparam int COLS   = 5;
   localparam int ROWS   = 5;

   typedef logic [PAGE_W-1:0] page_t;
   typedef logic [COLS-1:0]   col_par_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_EMIT = 2'd2
   } state_e;

   function automatic col_par_t col_parity(input page_t p);
      col_par_t c;
      for (int x = 0; x < COLS; x++) begin
         c[x] = 1'b0;
         for (int y = 0; y < ROWS; y++) begin
            c[x] = c[x] ^ p[COLS*y + x];
         end
      end
      return c;
   endfunction

endpackage

// File: rtl/theta_slice.sv
// Combinational theta for one slice.
//   page       in  : slice z
//   par_cur    in  : column parities of slice z
//   par_prev   in  : column parities of slice z-1 (cyclic)
//   theta_page out : page with D[x] folded into every row
module theta_slice
   import keccak_pkg::*;
(
   input  page_t    page,
   input  col_par_t par_cur,
   input  col_par_t par_prev,
   output page_t    theta_page
);

   col_par_t d;

   always_comb begin
      for (int x = 0; x < COLS; x++) begin
         d[x] = par_cur[(x + 4) % COLS] ^ par_prev[(x + 1) % COLS];
      end
   end

   always_comb begin
      theta_page = page;
      for (int y = 0; y < ROWS; y++) begin
         for (int x = 0; x < COLS; x++) begin
            theta_page[COLS*y + x] = page[COLS*y + x] ^ d[x];
         end
      end
   end

endmodule

// File: rtl/theta_stream.sv
// Keccak theta stream engine: buffers DEPTH slices of one state, then
// emits the theta-transformed slices in z order (or unchanged in bypass).
//   clk, rst (async, active-low)
//   start, bypass               : begin a state / pass-through select
//   in_valid, in_ready, in_page : input slice stream
//   out_valid, out_ready, out_page, out_idx, out_last : output slice stream
//   busy, done                  : engine active / end-of-state pulse
//
// state   | meaning
// ST_IDLE | waiting for start
// ST_LOAD | accepting slices into the buffer, z = write index
// ST_EMIT | presenting slice z, advancing on each accepted output
module theta_stream
   import keccak_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic            bypass,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [24:0]     in_page,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [24:0]     out_page,
   output logic [IDXW-1:0] out_idx,
   output logic            out_last,
   output logic            busy,
   output logic            done
);

   localparam logic [IDXW-1:0] Z_LAST = IDXW'(DEPTH - 1);

   state_e          state;
   logic [IDXW-1:0] z;
   logic [IDXW-1:0] z_prev;
   logic            byp_q;
   logic            done_q;

   page_t    page_mem [DEPTH];
   col_par_t par_mem  [DEPTH];

   page_t    theta_page;
   logic     in_hs;
   logic     out_hs;
   logic     z_at_last;

   assign in_ready  = (state == ST_LOAD);
   assign out_valid = (state == ST_EMIT);
   assign busy      = (state != ST_IDLE);
   assign done      = done_q;

   assign in_hs     = in_ready & in_valid;
   assign out_hs    = out_valid & out_ready;
   assign z_at_last = (z == Z_LAST);

   // With a single slice the previous slice is the slice itself.
   assign z_prev = (DEPTH == 1) ? '0 : z - IDXW'(1);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_IDLE;
         z      <= '0;
         byp_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  byp_q <= bypass;
                  z     <= '0;
                  state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (in_hs) begin
                  if (z_at_last) begin
                     z     <= '0;
                     state <= ST_EMIT;
                  end else begin
                     z <= z + IDXW'(1);
                  end
               end
            end
            ST_EMIT: begin
               if (out_hs) begin
                  if (z_at_last) begin
                     z      <= '0;
                     state  <= ST_IDLE;
                     done_q <= 1'b1;
                  end else begin
                     z <= z + IDXW'(1);
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
               z     <= '0;
            end
         endcase
      end
   end

   // Slice buffer and its column parities carry no reset; they are
   // always fully rewritten before being read.
   always_ff @(posedge clk) begin
      if (in_hs) begin
         page_mem[z] <= in_page;
         par_mem[z]  <= col_parity(in_page);
      end
   end

   theta_slice u_theta_slice (
      .page       (page_mem[z]),
      .par_cur    (par_mem[z]),
      .par_prev   (par_mem[z_prev]),
      .theta_page (theta_page)
   );

   always_comb begin
      out_page = '0;
      if (out_valid) begin
         out_page = byp_q ? page_mem[z] : theta_page;
      end
   end

   assign out_idx  = out_valid ? z : '0;
   assign out_last = out_valid & z_at_last;

endmodule
